// File: rtl/tag_sort_list_mc_pkg.sv
// Shared node/state types and pool constants for the multi-channel tag-sort list.
package tag_sort_pkg;

    localparam int TAG_W    = 4;
    localparam int PID_W    = 4;
    localparam int ADDR_W   = 4;
    localparam int IDX_W    = 4;
    localparam int INIT_CNT = 2 ** IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PID_W-1:0]  pack_id;
        logic [ADDR_W-1:0] pack_addr;
        logic [IDX_W-1:0]  next;
        logic              last;
    } node_t;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        POP,
        WALK,
        LINK
    } state_t;

endpackage

// File: rtl/tag_sort_list_mc_if.sv
// Request/response and status bundle of tag_sort_list_mc; slave = storage, master = client.
interface tag_sort_list_mc_if #(
    parameter int TAG_VALUE_WIDTH        = 4,
    parameter int PCK_ID_WIDTH           = 4,
    parameter int SPB_ADDR_WIDTH         = 4,
    parameter int TAG_STORAGE_ADDR_WIDTH = 4,
    parameter int NUM_CH                 = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                              wr_req;
    logic [CH_W-1:0]                   wr_ch;
    logic [TAG_VALUE_WIDTH-1:0]        i_tag_value;
    logic [PCK_ID_WIDTH-1:0]           i_pack_id;
    logic [SPB_ADDR_WIDTH-1:0]         i_pack_addr;
    logic                              wr_ack;
    logic                              wr_done;
    logic                              wr_err;
    logic                              rd_req;
    logic [CH_W-1:0]                   rd_ch;
    logic                              rd_valid;
    logic                              rd_err;
    logic [TAG_VALUE_WIDTH-1:0]        op_tag;
    logic [PCK_ID_WIDTH-1:0]           op_pak_id;
    logic [SPB_ADDR_WIDTH-1:0]         op_addr;
    logic                              busy;
    logic [NUM_CH-1:0]                 ch_empty;
    logic                              full;
    logic [TAG_STORAGE_ADDR_WIDTH:0]   free_cnt;

    modport master (
        output wr_req, wr_ch, i_tag_value, i_pack_id, i_pack_addr, rd_req, rd_ch,
        input  wr_ack, wr_done, wr_err, rd_valid, rd_err, op_tag, op_pak_id, op_addr,
               busy, ch_empty, full, free_cnt
    );

    modport slave (
        input  wr_req, wr_ch, i_tag_value, i_pack_id, i_pack_addr, rd_req, rd_ch,
        output wr_ack, wr_done, wr_err, rd_valid, rd_err, op_tag, op_pak_id, op_addr,
               busy, ch_empty, full, free_cnt
    );

endinterface

// File: rtl/tag_sort_list_mc_tag_cmp.sv
// Tag "less than" comparator; TAG_WRAP_EN selects serial-number ordering, else plain unsigned.
module tag_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
`ifdef TAG_WRAP_EN
    logic [W-1:0] diff;

    // a<b when (b-a) mod 2**W lies in [1, 2**(W-1)-1]: non-zero with MSB clear
    always_comb begin
        diff = b - a;
        lt   = (diff != '0) && !diff[W-1];
    end
`else
    always_comb begin
        lt = (a < b);
    end
`endif
endmodule

// File: rtl/tag_sort_list_mc.sv
// NUM_CH ascending-tag linked lists in one shared node pool with a LIFO free list.
// Build option: TAG_WRAP_EN (wrap-around tag ordering, resolved inside tag_cmp).
module tag_sort_list_mc
    import tag_sort_pkg::*;
#(
    parameter int TAG_VALUE_WIDTH        = TAG_W,
    parameter int PCK_ID_WIDTH           = PID_W,
    parameter int SPB_ADDR_WIDTH         = ADDR_W,
    parameter int TAG_STORAGE_ADDR_WIDTH = IDX_W,
    parameter int NUM_CH                 = 2
) (
    input logic               clk,
    input logic               rst,
    tag_sort_list_mc_if.slave bus
);
    localparam int M    = TAG_STORAGE_ADDR_WIDTH;
    localparam int D    = 2 ** M;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [M:0]   FULL_CNT = (M+1)'(INIT_CNT);
    localparam logic [M-1:0] LAST_IDX = M'(D - 1);

    state_t                      state_q, state_d;
    logic [M-1:0]                init_idx_q, init_idx_d;
    logic [M-1:0]                free_head_q, free_head_d;
    logic [M:0]                  free_cnt_q, free_cnt_d;
    logic [M-1:0]                head_q [NUM_CH];
    logic [M-1:0]                head_d [NUM_CH];
    logic [NUM_CH-1:0]           ch_empty_q, ch_empty_d;
    logic [CH_W-1:0]             req_ch_q, req_ch_d;
    logic [TAG_VALUE_WIDTH-1:0]  new_tag_q, new_tag_d;
    logic [PCK_ID_WIDTH-1:0]     new_id_q, new_id_d;
    logic [SPB_ADDR_WIDTH-1:0]   new_addr_q, new_addr_d;
    logic [M-1:0]                new_idx_q, new_idx_d;
    logic [M-1:0]                cur_q, cur_d;
    logic [M-1:0]                prev_q, prev_d;
    logic                        cur_valid_q, cur_valid_d;
    logic                        prev_valid_q, prev_valid_d;
    logic                        drop_q, drop_d;
    logic                        busy_q, busy_d;
    logic                        full_q, full_d;
    logic                        wr_ack_q, wr_ack_d;
    logic                        wr_done_q, wr_done_d;
    logic                        wr_err_q, wr_err_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_err_q, rd_err_d;
    logic [TAG_VALUE_WIDTH-1:0]  op_tag_q, op_tag_d;
    logic [PCK_ID_WIDTH-1:0]     op_id_q, op_id_d;
    logic [SPB_ADDR_WIDTH-1:0]   op_addr_q, op_addr_d;
    node_t                       pool_q [D];
    node_t                       pool_d [D];
    node_t                       head_node;
    logic                        new_lt_cur;

    assign head_node = pool_q[head_q[req_ch_q]];

    tag_cmp #(.W(TAG_VALUE_WIDTH)) u_cmp (
        .a  (new_tag_q),
        .b  (pool_q[cur_q].tag),
        .lt (new_lt_cur)
    );

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        free_head_d  = free_head_q;
        free_cnt_d   = free_cnt_q;
        head_d       = head_q;
        ch_empty_d   = ch_empty_q;
        req_ch_d     = req_ch_q;
        new_tag_d    = new_tag_q;
        new_id_d     = new_id_q;
        new_addr_d   = new_addr_q;
        new_idx_d    = new_idx_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        cur_valid_d  = cur_valid_q;
        prev_valid_d = prev_valid_q;
        drop_d       = drop_q;
        op_tag_d     = op_tag_q;
        op_id_d      = op_id_q;
        op_addr_d    = op_addr_q;
        wr_ack_d     = 1'b0;
        wr_done_d    = 1'b0;
        wr_err_d     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_err_d     = 1'b0;
        pool_d       = pool_q;

        case (state_q)
            INIT: begin
                pool_d[init_idx_q]      = '0;
                pool_d[init_idx_q].next = init_idx_q + 1'b1;
                pool_d[init_idx_q].last = (init_idx_q == LAST_IDX);
                init_idx_d              = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d     = IDLE;
                    free_head_d = '0;
                    free_cnt_d  = FULL_CNT;
                end
            end
            IDLE: begin
                if (!busy_q) begin
                    if (bus.rd_req) begin
                        req_ch_d = bus.rd_ch;
                        state_d  = POP;
                    end else if (bus.wr_req) begin
                        wr_ack_d     = 1'b1;
                        req_ch_d     = bus.wr_ch;
                        new_tag_d    = bus.i_tag_value;
                        new_id_d     = bus.i_pack_id;
                        new_addr_d   = bus.i_pack_addr;
                        prev_valid_d = 1'b0;
                        state_d      = LINK;
                        drop_d       = (free_cnt_q == '0);
                        if (free_cnt_q != '0) begin
                            new_idx_d   = free_head_q;
                            free_head_d = pool_q[free_head_q].next;
                            cur_d       = head_q[bus.wr_ch];
                            cur_valid_d = !ch_empty_q[bus.wr_ch];
                            state_d     = WALK;
                        end
                    end
                end
            end
            POP: begin
                rd_valid_d = 1'b1;
                state_d    = IDLE;
                if (ch_empty_q[req_ch_q]) begin
                    rd_err_d = 1'b1;
                end else begin
                    op_tag_d         = head_node.tag;
                    op_id_d          = head_node.pack_id;
                    op_addr_d        = head_node.pack_addr;
                    head_d[req_ch_q] = head_node.next;
                    if (head_node.last) begin
                        ch_empty_d[req_ch_q] = 1'b1;
                    end
                    pool_d[head_q[req_ch_q]].next = free_head_q;
                    pool_d[head_q[req_ch_q]].last = (free_cnt_q == '0);
                    free_head_d = head_q[req_ch_q];
                    free_cnt_d  = free_cnt_q + 1'b1;
                end
            end
            WALK: begin
                // An exhausted list still spends one cycle here so tail inserts cost k+2 like the rest
                if (!cur_valid_q || new_lt_cur) begin
                    state_d = LINK;
                end else begin
                    prev_d       = cur_q;
                    prev_valid_d = 1'b1;
                    if (pool_q[cur_q].last) begin
                        cur_valid_d = 1'b0;
                    end else begin
                        cur_d = pool_q[cur_q].next;
                    end
                end
            end
            LINK: begin
                wr_done_d = 1'b1;
                wr_err_d  = drop_q;
                state_d   = IDLE;
                if (!drop_q) begin
                    pool_d[new_idx_q].tag       = new_tag_q;
                    pool_d[new_idx_q].pack_id   = new_id_q;
                    pool_d[new_idx_q].pack_addr = new_addr_q;
                    pool_d[new_idx_q].next      = cur_q;
                    pool_d[new_idx_q].last      = !cur_valid_q;
                    if (prev_valid_q) begin
                        pool_d[prev_q].next = new_idx_q;
                        pool_d[prev_q].last = 1'b0;
                    end else begin
                        head_d[req_ch_q] = new_idx_q;
                    end
                    ch_empty_d[req_ch_q] = 1'b0;
                    free_cnt_d           = free_cnt_q - 1'b1;
                end
            end
            default: state_d = INIT;
        endcase

        busy_d = (state_d != IDLE) || (state_q == INIT);
        full_d = (free_cnt_d == '0) && (state_d != INIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            free_head_q  <= '0;
            free_cnt_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                head_q[i] <= '0;
            end
            ch_empty_q   <= '1;
            req_ch_q     <= '0;
            new_tag_q    <= '0;
            new_id_q     <= '0;
            new_addr_q   <= '0;
            new_idx_q    <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            cur_valid_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            wr_done_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            op_tag_q     <= '0;
            op_id_q      <= '0;
            op_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            free_head_q  <= free_head_d;
            free_cnt_q   <= free_cnt_d;
            head_q       <= head_d;
            ch_empty_q   <= ch_empty_d;
            req_ch_q     <= req_ch_d;
            new_tag_q    <= new_tag_d;
            new_id_q     <= new_id_d;
            new_addr_q   <= new_addr_d;
            new_idx_q    <= new_idx_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            cur_valid_q  <= cur_valid_d;
            prev_valid_q <= prev_valid_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            wr_ack_q     <= wr_ack_d;
            wr_done_q    <= wr_done_d;
            wr_err_q     <= wr_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            op_tag_q     <= op_tag_d;
            op_id_q      <= op_id_d;
            op_addr_q    <= op_addr_d;
        end
    end

    // Pool contents are rebuilt by INIT after every reset, so the array carries no reset
    always_ff @(posedge clk) begin
        pool_q <= pool_d;
    end

    assign bus.wr_ack    = wr_ack_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_err    = rd_err_q;
    assign bus.op_tag    = op_tag_q;
    assign bus.op_pak_id = op_id_q;
    assign bus.op_addr   = op_addr_q;
    assign bus.busy      = busy_q;
    assign bus.ch_empty  = ch_empty_q;
    assign bus.full      = full_q;
    assign bus.free_cnt  = free_cnt_q;

endmodule
